// File: rtl/self_test_scheduler.sv
// self_test_scheduler: shares one self-test FSM between N_REQ requesters.
// Requests are arbitrated round-robin. Each granted run gets a one-cycle start
// pulse and a completion wait bounded by a timeout. The requester then receives
// a one-cycle ack with pass/timeout flags, and saturating statistics are kept.
// An idle gap is enforced between consecutive runs.
module self_test_scheduler #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 8,
    parameter int CNT_W          = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           ack,
    output logic                       result_ok,
    output logic                       result_timeout,
    output logic                       st_start,
    input  logic                       st_done,
    input  logic                       st_pass,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    input  logic                       clear_cnt,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic [CNT_W-1:0]           timeout_cnt
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_REPORT = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [ID_W-1:0]        ptr_r;
    logic [ID_W-1:0]        active_id_r;
    logic [TMR_W-1:0]       timer_r;
    logic [N_REQ-1:0]       ack_r;
    logic                   ok_r;
    logic                   to_r;
    logic                   st_start_r;
    logic                   busy_r;
    logic [CNT_W-1:0]       pass_cnt_r;
    logic [CNT_W-1:0]       fail_cnt_r;
    logic [CNT_W-1:0]       timeout_cnt_r;

    logic [ID_W-1:0]        grant_s;
    logic                   any_req_s;
    logic                   expire_s;
    logic [N_REQ-1:0]       ack_s;
    logic                   ok_s;
    logic                   to_s;
    logic                   st_start_s;
    logic                   busy_s;
    logic [ID_W-1:0]        ptr_next_s;

    // First requester at or after the pointer, wrapping modulo N_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = {ID_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!found && r[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Increment that holds at the all-ones ceiling.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Arbitration and timer-expiry decode.
    always_comb begin
        grant_s    = rr_pick(req, ptr_r);
        any_req_s  = |req;
        expire_s   = (timer_r <= TMR_W'(1));
        ptr_next_s = (active_id_r == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : active_id_r + ID_W'(1);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a done pulse beats a simultaneous timer expiry.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (any_req_s) begin
                    next_state_s = S_START;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_START:  next_state_s = S_WAIT;
            S_WAIT: begin
                if (st_done || expire_s) begin
                    next_state_s = S_REPORT;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_REPORT: next_state_s = S_GAP;
            S_GAP: begin
                if (expire_s) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_GAP;
                end
            end
            default:  next_state_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the current state.
    always_comb begin
        ack_s      = {N_REQ{1'b0}};
        ok_s       = 1'b0;
        to_s       = 1'b0;
        st_start_s = 1'b0;
        busy_s     = (next_state_s != S_IDLE);
        case (state_r)
            S_IDLE: begin
                if (any_req_s) begin
                    st_start_s = 1'b1;
                end else begin
                    st_start_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (st_done) begin
                    ack_s = {{(N_REQ-1){1'b0}}, 1'b1} << active_id_r;
                    ok_s  = st_pass;
                end else if (expire_s) begin
                    ack_s = {{(N_REQ-1){1'b0}}, 1'b1} << active_id_r;
                    to_s  = 1'b1;
                end else begin
                    ack_s = {N_REQ{1'b0}};
                end
            end
            default: begin
                ack_s = {N_REQ{1'b0}};
            end
        endcase
    end

    // Grant capture, round-robin pointer and shared wait/gap timer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_id_r <= {ID_W{1'b0}};
            ptr_r       <= {ID_W{1'b0}};
            timer_r     <= {TMR_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (any_req_s) begin
                        active_id_r <= grant_s;
                    end
                end
                S_START: timer_r <= TMR_W'(TIMEOUT_CYCLES);
                S_WAIT, S_GAP: begin
                    if (timer_r != {TMR_W{1'b0}}) begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                S_REPORT: begin
                    ptr_r   <= ptr_next_s;
                    timer_r <= TMR_W'(GAP_CYCLES);
                end
                default: timer_r <= {TMR_W{1'b0}};
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_r      <= {N_REQ{1'b0}};
            ok_r       <= 1'b0;
            to_r       <= 1'b0;
            st_start_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            ack_r      <= ack_s;
            ok_r       <= ok_s;
            to_r       <= to_s;
            st_start_r <= st_start_s;
            busy_r     <= busy_s;
        end
    end

    // Saturating statistics, updated from the latched verdict during REPORT; clear has priority.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pass_cnt_r    <= {CNT_W{1'b0}};
            fail_cnt_r    <= {CNT_W{1'b0}};
            timeout_cnt_r <= {CNT_W{1'b0}};
        end else if (clear_cnt) begin
            pass_cnt_r    <= {CNT_W{1'b0}};
            fail_cnt_r    <= {CNT_W{1'b0}};
            timeout_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == S_REPORT) begin
            if (ok_r) begin
                pass_cnt_r <= sat_inc(pass_cnt_r);
            end else begin
                fail_cnt_r <= sat_inc(fail_cnt_r);
            end
            if (to_r) begin
                timeout_cnt_r <= sat_inc(timeout_cnt_r);
            end
        end
    end

    assign ack            = ack_r;
    assign result_ok      = ok_r;
    assign result_timeout = to_r;
    assign st_start       = st_start_r;
    assign busy           = busy_r;
    assign active_id      = active_id_r;
    assign pass_cnt       = pass_cnt_r;
    assign fail_cnt       = fail_cnt_r;
    assign timeout_cnt    = timeout_cnt_r;

endmodule

// File: tb/tb_self_test_scheduler.sv
// Directed, scoreboard-based bench for self_test_scheduler. A second instance
// with 2-bit counters shares all inputs and exercises counter saturation.
module tb_self_test_scheduler;

    localparam int T = 16;
    localparam int G = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        st_done, st_pass, clear_cnt;
    logic [3:0]  ack;
    logic        result_ok, result_timeout, st_start, busy;
    logic [1:0]  active_id;
    logic [15:0] pass_cnt, fail_cnt, timeout_cnt;
    logic [3:0]  s_ack;
    logic        s_ok, s_to, s_start, s_busy;
    logic [1:0]  s_id;
    logic [1:0]  s_pass, s_fail, s_tocnt;

    int checks = 0;
    int failures = 0;
    int start_pulses = 0;
    int ack_pulses = 0;
    int e_pass = 0, e_fail = 0, e_to = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic       ok;
        logic       to;
    } exp_t;
    exp_t sb[$];

    self_test_scheduler #(.N_REQ(4), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .req(req), .ack(ack), .result_ok(result_ok),
        .result_timeout(result_timeout), .st_start(st_start), .st_done(st_done),
        .st_pass(st_pass), .busy(busy), .active_id(active_id), .clear_cnt(clear_cnt),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt));

    self_test_scheduler #(.N_REQ(4), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .req(req), .ack(s_ack), .result_ok(s_ok),
        .result_timeout(s_to), .st_start(s_start), .st_done(st_done),
        .st_pass(st_pass), .busy(s_busy), .active_id(s_id), .clear_cnt(clear_cnt),
        .pass_cnt(s_pass), .fail_cnt(s_fail), .timeout_cnt(s_tocnt));

    always #5 clock = ~clock;

    // Pulse counters observed away from the active edge.
    always @(negedge clock) begin
        if (st_start) start_pulses++;
        if (ack != 4'b0000) ack_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check_cnts(input string tag);
        check({tag, "_pass"}, 32'(pass_cnt), e_pass);
        check({tag, "_fail"}, 32'(fail_cnt), e_fail);
        check({tag, "_tmo"},  32'(timeout_cnt), e_to);
        check({tag, "_spass"}, 32'(s_pass), sat3(e_pass));
        check({tag, "_sfail"}, 32'(s_fail), sat3(e_fail));
        check({tag, "_stmo"},  32'(s_tocnt), sat3(e_to));
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clock);
            if (st_start) seen = 1'b1;
        end
    endtask

    // One run: d = cycles after st_start to drive st_done (0 = never).
    task automatic do_run(input string tag, input int exp_id, input int d,
                          input bit pass, input bit clr);
        bit   seen;
        bit   early;
        int   lat;
        int   s0;
        exp_t e, got;
        s0 = start_pulses;
        wait_start(seen);
        check({tag, "_start"}, 32'(seen), 1);
        check({tag, "_id"}, 32'(active_id), exp_id);
        e.ack = 4'b0001 << exp_id;
        e.ok  = (d != 0) && pass;
        e.to  = (d == 0);
        sb.push_back(e);
        lat   = (d == 0) ? T + 1 : d + 1;
        early = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clock);
            if (i < lat && ack != 4'b0000) early = 1'b1;
            if (i == d) begin
                st_done = 1'b1;
                st_pass = pass;
            end else begin
                st_done = 1'b0;
                st_pass = 1'b0;
            end
        end
        check({tag, "_noearly"}, 32'(early), 0);
        got = sb.pop_front();
        check({tag, "_ack"}, 32'(ack), 32'(got.ack));
        check({tag, "_ok"}, 32'(result_ok), 32'(got.ok));
        check({tag, "_tmo_flag"}, 32'(result_timeout), 32'(got.to));
        if (clr) clear_cnt = 1'b1;
        if (clr) begin
            e_pass = 0; e_fail = 0; e_to = 0;
        end else if (d == 0) begin
            e_fail++; e_to++;
        end else if (pass) begin
            e_pass++;
        end else begin
            e_fail++;
        end
        @(negedge clock);
        clear_cnt   = 1'b0;
        req[exp_id] = 1'b0;
        check({tag, "_ackgone"}, 32'(ack), 0);
        check({tag, "_one_start"}, start_pulses - s0, 1);
        check_cnts(tag);
        repeat (G - 1) @(negedge clock);
        check({tag, "_busy_gap"}, 32'(busy), 1);
        @(negedge clock);
        check({tag, "_busy_idle"}, 32'(busy), 0);
    endtask

    initial begin
        bit seen;
        int a0;
        reset = 1'b0; req = 4'b0000; st_done = 1'b0; st_pass = 1'b0; clear_cnt = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(st_start), 0);
        check("rst_id", 32'(active_id), 0);
        check_cnts("rst");
        reset = 1'b1;
        @(negedge clock);
        check("idle_busy", 32'(busy), 0);

        // Round-robin fairness with all four requesting.
        req = 4'b1111;
        do_run("rr0", 0, 3, 1'b1, 1'b0);
        do_run("rr1", 1, 4, 1'b1, 1'b0);
        do_run("rr2", 2, 2, 1'b1, 1'b0);
        do_run("rr3", 3, 6, 1'b1, 1'b0);

        // Clear while idle.
        clear_cnt = 1'b1;
        @(negedge clock);
        clear_cnt = 1'b0;
        e_pass = 0; e_fail = 0; e_to = 0;
        check_cnts("clr_idle");

        // Single pass, timeout, and done exactly at expiry.
        req = 4'b0001;
        do_run("single", 0, 5, 1'b1, 1'b0);
        req = 4'b0100;
        do_run("timeout", 2, 0, 1'b0, 1'b0);
        req = 4'b1000;
        do_run("expiry", 3, T, 1'b1, 1'b0);

        clear_cnt = 1'b1;
        @(negedge clock);
        clear_cnt = 1'b0;
        e_pass = 0; e_fail = 0; e_to = 0;

        // Saturation on the 2-bit instance, one failing run, then clear during REPORT.
        for (int k = 0; k < 5; k++) begin
            req = 4'b0001;
            do_run("sat", 0, 2, 1'b1, 1'b0);
        end
        req = 4'b0010;
        do_run("fail", 1, 3, 1'b0, 1'b0);
        req = 4'b0001;
        do_run("clr_rep", 0, 2, 1'b1, 1'b1);

        // Reset asserted mid-WAIT, between clock edges.
        req = 4'b0010;
        wait_start(seen);
        check("mid_start", 32'(seen), 1);
        check("mid_id", 32'(active_id), 1);
        repeat (3) @(negedge clock);
        #2;
        a0 = ack_pulses;
        reset = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_st_start", 32'(st_start), 0);
        check("mid_id_rst", 32'(active_id), 0);
        req = 4'b0000;
        e_pass = 0; e_fail = 0; e_to = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("mid_no_ack", ack_pulses - a0, 0);
        check_cnts("mid_cnt");
        req = 4'b1001;
        do_run("fresh", 0, 3, 1'b1, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
